// File: rtl/cmd_pkg.sv
// Constants shared by the GPIO command path: opcodes, cmdreg field layout and
// the sequencer state encoding.
package cmd_pkg;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_COMPL  = 2'd1;
    localparam logic [1:0] OP_OFFSET = 2'd2;
    localparam logic [1:0] OP_MULT   = 2'd3;

    localparam int GO_BIT   = 0;
    localparam int ELEM_LSB = 3;
    localparam int OP_LSB   = 6;
    localparam int ELEM_W   = 3;
    localparam int OP_W     = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_PRESENT = 2'd3;

    typedef struct packed {
        logic [OP_W-1:0]   code;
        logic [ELEM_W-1:0] elem;
        logic              go;
    } cmd_fields_t;

    function automatic cmd_fields_t decode_cmd(input logic [7:0] c);
        cmd_fields_t f;
        f.go   = c[GO_BIT];
        f.elem = c[ELEM_LSB +: ELEM_W];
        f.code = c[OP_LSB +: OP_W];
        return f;
    endfunction

endpackage

// File: rtl/cmd_sequencer_edge_detect.sv
// Rising-edge detector for synchronized GPIO strobes. History resets low, so a
// level already high when reset releases reports one edge.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/cmd_sequencer.sv
// GPIO command front end: detects a go edge, fetches one BRAM word and presents
// it with the latched operands to the datapath over valid/ready.
module cmd_sequencer
    import cmd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        cmdreg,
    input  logic [7:0]        mult_in,
    input  logic [7:0]        offset_in,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_adr,
    input  logic [DATA_W-1:0] bram_rd,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [1:0]        op_code,
    output logic [DATA_W-1:0] op_data,
    output logic [7:0]        op_mult,
    output logic [7:0]        op_offset,
    output logic              busy,
    output logic              done,
    output logic              cmd_dropped,
    output logic [1:0]        dbg_state
);

    // Handshake: op_valid rises only in PRESENT and then holds, with every op_*
    // field frozen, until the first cycle op_ready is high; that cycle is the
    // transfer. op_ready outside PRESENT has no effect.

    localparam int CNT_W = 3;

    cmd_fields_t cmd;
    logic        go_rise;

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              bram_en_q,   bram_en_d;
    logic [ADDR_W-1:0] bram_adr_q,  bram_adr_d;
    logic              op_valid_q,  op_valid_d;
    logic [1:0]        op_code_q,   op_code_d;
    logic [DATA_W-1:0] op_data_q,   op_data_d;
    logic [7:0]        op_mult_q,   op_mult_d;
    logic [7:0]        op_offset_q, op_offset_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              dropped_q,   dropped_d;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmdreg[2:1];

    assign cmd = decode_cmd(cmdreg);

    edge_detect u_go_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (cmd.go),
        .rise_o (go_rise)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bram_en_d   = 1'b0;
        bram_adr_d  = bram_adr_q;
        op_valid_d  = op_valid_q;
        op_code_d   = op_code_q;
        op_data_d   = op_data_q;
        op_mult_d   = op_mult_q;
        op_offset_d = op_offset_q;
        done_d      = 1'b0;
        dropped_d   = dropped_q;

        case (state_q)
            ST_IDLE: begin
                if (go_rise) begin
                    op_code_d   = cmd.code;
                    op_mult_d   = mult_in;
                    op_offset_d = offset_in;
                    dropped_d   = 1'b0;
                    // Enable and address are registered, so they are set up on
                    // entry and are visible during the ISSUE cycle itself.
                    bram_en_d   = 1'b1;
                    bram_adr_d  = ADDR_W'({cmd.elem, 2'b00});
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(RD_LAT);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    op_data_d  = bram_rd;
                    op_valid_d = 1'b1;
                    state_d    = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (op_valid_q && op_ready) begin
                    op_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new go outside IDLE (including the handshake cycle) is lost.
        if (go_rise && (state_q != ST_IDLE)) begin
            dropped_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bram_en_q   <= 1'b0;
            bram_adr_q  <= '0;
            op_valid_q  <= 1'b0;
            op_code_q   <= '0;
            op_data_q   <= '0;
            op_mult_q   <= '0;
            op_offset_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bram_en_q   <= bram_en_d;
            bram_adr_q  <= bram_adr_d;
            op_valid_q  <= op_valid_d;
            op_code_q   <= op_code_d;
            op_data_q   <= op_data_d;
            op_mult_q   <= op_mult_d;
            op_offset_q <= op_offset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dropped_q   <= dropped_d;
        end
    end

    assign bram_en     = bram_en_q;
    assign bram_adr    = bram_adr_q;
    assign op_valid    = op_valid_q;
    assign op_code     = op_code_q;
    assign op_data     = op_data_q;
    assign op_mult     = op_mult_q;
    assign op_offset   = op_offset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cmd_dropped = dropped_q;
    assign dbg_state   = state_q;

endmodule
